// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: NOP word, default reset PC,
// RV32 field positions and fetch FSM state encodings.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: power-of-2 deep synchronous FIFO with single-cycle flush,
// used both for returned {inst, pc} entries and for pcs of requests in flight.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          w_pop;

    assign w_pop = pop && (r_cnt != '0);
    assign full  = (r_cnt == (AW+1)'(DEPTH));
    assign empty = (r_cnt == '0);
    assign count = r_cnt;
    assign head  = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (push)  r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Storage is not reset; head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr] <= din;
    end

    // Upstream credit keeps outstanding+occupancy within DEPTH, so this never fires.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order instruction queue,
// redirect flush. Define FETCH_BYPASS_EN to forward a response straight to inst when the queue is empty.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int               DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            consume,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e       r_state;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_last_pc;
    logic [CW-1:0]      r_out;
    logic [CW-1:0]      r_drop;

    logic               w_fire;
    logic               w_rsp_keep;
    logic               w_byp;
    logic [CW-1:0]      w_out_nxt;
    logic [CW:0]        w_used;

    logic               w_dq_push;
    logic               w_dq_pop;
    logic               w_dq_full;
    logic               w_dq_empty;
    logic [CW-1:0]      w_dq_cnt;
    logic [XLEN+31:0]   w_dq_head;

    logic               w_pcq_full;
    logic               w_pcq_empty;
    logic [CW-1:0]      w_pcq_cnt;
    logic [XLEN-1:0]    w_pcq_head;
    logic               w_unused;

    // Credit counts words in flight plus words buffered, so a response always has a slot.
    assign w_used         = {1'b0, r_out} + {1'b0, w_dq_cnt};
    assign imem_req_valid = rst_n && (r_state == ST_RUN) && !redirect_valid
                            && (w_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_out_nxt      = r_out + CW'(w_fire) - CW'(imem_rsp_valid);
    assign w_rsp_keep     = imem_rsp_valid && (r_drop == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign w_byp = w_dq_empty && w_rsp_keep;
`else
    assign w_byp = 1'b0;
`endif

    assign w_dq_push = w_rsp_keep && !(w_byp && consume);
    assign w_dq_pop  = consume && !w_dq_empty && !redirect_valid;

    fetch_queue #(.DEPTH(DEPTH), .W(XLEN+32)) u_dq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_dq_push),
        .pop   (w_dq_pop),
        .flush (redirect_valid),
        .din   ({imem_rsp_data, w_pcq_head}),
        .full  (w_dq_full),
        .empty (w_dq_empty),
        .count (w_dq_cnt),
        .head  (w_dq_head)
    );

    // Addresses of live requests; only responses that will be kept consume an entry.
    fetch_queue #(.DEPTH(DEPTH), .W(XLEN)) u_pcq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fire),
        .pop   (w_rsp_keep),
        .flush (redirect_valid),
        .din   (r_pc),
        .full  (w_pcq_full),
        .empty (w_pcq_empty),
        .count (w_pcq_cnt),
        .head  (w_pcq_head)
    );

    assign w_unused = ^{w_dq_full, w_pcq_full, w_pcq_empty, w_pcq_cnt};

    assign inst_valid = !w_dq_empty || w_byp;
    assign inst       = !w_dq_empty ? w_dq_head[XLEN+31:XLEN] : (w_byp ? imem_rsp_data : NOP_INST);
    assign inst_pc    = !w_dq_empty ? w_dq_head[XLEN-1:0]     : (w_byp ? w_pcq_head    : r_last_pc);

    assign opcode = inst[OPC_LSB +: 7];
    assign rd     = inst[RD_LSB  +: 5];
    assign funct3 = inst[F3_LSB  +: 3];
    assign rs1    = inst[RS1_LSB +: 5];
    assign rs2    = inst[RS2_LSB +: 5];
    assign funct7 = inst[F7_LSB  +: 7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_PC;
            r_last_pc <= RESET_PC;
            r_out     <= '0;
            r_drop    <= '0;
        end else begin
            r_last_pc <= inst_pc;
            r_out     <= w_out_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the wrong path.
                r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
                r_drop  <= w_out_nxt;
                r_state <= (w_out_nxt != '0) ? ST_FLUSH : ST_RUN;
            end else begin
                if (w_fire)
                    r_pc <= r_pc + XLEN'(4);
                if (imem_rsp_valid && (r_drop != '0))
                    r_drop <= r_drop - CW'(1);
                if ((r_state == ST_FLUSH) && (r_drop == '0))
                    r_state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): pc-level transaction model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        consume;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .consume(consume),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return {a[26:2], 7'b0110011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string nm, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (imem_req_valid) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: no request within %0d cycles", nm, bound);
    endtask

    task automatic wait_iv(input string nm, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (inst_valid) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: no instruction within %0d cycles", nm, bound);
    endtask

    task automatic do_reset(input int lat);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        consume = 1'b0;
        imem_req_ready = 1'b1;
        mem_lat = lat;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Memory: fixed latency of mem_lat cycles, in order, forgets everything on reset.
    logic        p_v [3];
    logic [31:0] p_a [3];
    initial begin
        logic        nf;
        logic [31:0] na;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        for (int i = 0; i < 3; i++) begin p_v[i] = 1'b0; p_a[i] = 32'h0; end
        forever begin
            @(negedge clk);
            nf = imem_req_valid && imem_req_ready && rst_n;
            na = imem_req_addr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) p_v[i] = 1'b0;
                imem_rsp_valid = 1'b0;
            end else begin
                p_v[2] = p_v[1]; p_a[2] = p_a[1];
                p_v[1] = p_v[0]; p_a[1] = p_a[0];
                p_v[0] = nf;     p_a[0] = na;
                imem_rsp_valid = p_v[mem_lat-1];
                imem_rsp_data  = mem_word(p_a[mem_lat-1]);
            end
        end
    end

    // Model: fetch pc, pcs in flight, pcs buffered, words still to drop, flush flag.
    logic [31:0] m_pc;
    logic [31:0] m_last;
    logic [31:0] m_pend [$];
    logic [31:0] m_buf  [$];
    int          m_drop;
    bit          m_flush;

    always @(negedge clk) begin
        bit          exp_rv, exp_iv, exit_flush;
        logic [31:0] exp_pc, exp_inst, p;
        if (!rst_n) begin
            chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
            chk("rst_inst", inst, NOP);
            chk("rst_inst_pc", inst_pc, 32'h0);
            m_pc = 32'h0; m_last = 32'h0; m_drop = 0; m_flush = 0;
            m_pend.delete(); m_buf.delete();
        end else begin
            exp_rv   = !m_flush && !redirect_valid && (m_pend.size() + m_buf.size() < DEPTH);
            exp_iv   = (m_buf.size() > 0);
            exp_pc   = exp_iv ? m_buf[0] : m_last;
            exp_inst = exp_iv ? mem_word(m_buf[0]) : NOP;
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
            if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
            chk("inst", inst, exp_inst);
            chk("inst_pc", inst_pc, exp_pc);
            chk("opcode", {25'b0, opcode}, {25'b0, exp_inst[6:0]});
            chk("rd", {27'b0, rd}, {27'b0, exp_inst[11:7]});
            chk("funct3", {29'b0, funct3}, {29'b0, exp_inst[14:12]});
            chk("rs1", {27'b0, rs1}, {27'b0, exp_inst[19:15]});
            chk("rs2", {27'b0, rs2}, {27'b0, exp_inst[24:20]});
            chk("funct7", {25'b0, funct7}, {25'b0, exp_inst[31:25]});

            m_last = exp_pc;
            if (exp_iv && consume && !redirect_valid) void'(m_buf.pop_front());
            exit_flush = m_flush && (m_drop == 0);
            if (imem_rsp_valid && m_pend.size() > 0) begin
                p = m_pend.pop_front();
                if (m_drop > 0) m_drop--;
                else if (!redirect_valid) m_buf.push_back(p);
            end
            if (exp_rv && imem_req_ready) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (redirect_valid) begin
                m_buf.delete();
                m_drop  = m_pend.size();
                m_flush = (m_drop > 0);
                m_pc    = {redirect_pc[31:2], 2'b00};
            end else if (exit_flush) begin
                m_flush = 0;
            end
        end
    end

    initial begin
        int fires;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        consume = 1'b0;
        imem_req_ready = 1'b1;

        // A: streaming with consume every cycle, 1-cycle memory.
        do_reset(1);
        consume = 1'b1;
        @(negedge clk);
        chk("A_c0_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("A_c0_addr", imem_req_addr, 32'h0);
        tick; @(negedge clk);
        chk("A_c1_addr", imem_req_addr, 32'h4);
        tick; @(negedge clk);
        chk("A_c2_credit", {31'b0, imem_req_valid}, 32'd0);
        chk("A_c2_inst_pc", inst_pc, 32'h0);
        tick; @(negedge clk);
        chk("A_c3_addr", imem_req_addr, 32'h8);
        chk("A_c3_inst_pc", inst_pc, 32'h4);
        for (int i = 0; i < 24; i++) begin
            tick;
            imem_req_ready = (i % 3) != 2;
            consume        = (i % 4) != 3;
            redirect_valid = (i == 10);
            redirect_pc    = 32'h40;
        end
        tick;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;

        // B: consume held low fills exactly DEPTH slots.
        do_reset(1);
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) fires++;
        end
        chk("B_fires", 32'(fires), 32'd2);
        chk("B_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("B_inst_pc", inst_pc, 32'h0);
        chk("B_inst", inst, 32'h00A0_0093);
        chk("B_opcode", {25'b0, opcode}, 32'h13);
        chk("B_rd", {27'b0, rd}, 32'd1);
        chk("B_funct3", {29'b0, funct3}, 32'd0);
        chk("B_rs1", {27'b0, rs1}, 32'd0);
        chk("B_rs2", {27'b0, rs2}, 32'd10);
        chk("B_funct7", {25'b0, funct7}, 32'd0);

        // C: two outstanding on a 2-cycle memory, redirect to 0x100.
        do_reset(2);
        tick;
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        chk("C_redir_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick;
        redirect_valid = 1'b0;
        wait_req("C_wait_req", 10);
        chk("C_addr", imem_req_addr, 32'h100);
        tick;
        consume = 1'b1;
        wait_iv("C_wait_inst", 10);
        chk("C_inst_pc", inst_pc, 32'h100);
        chk("C_inst", inst, 32'h0000_2033);

        // D: redirect together with a response and consume.
        do_reset(1);
        consume = 1'b1;
        tick;
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        chk("D_rsp_present", {31'b0, imem_rsp_valid}, 32'd1);
        chk("D_head_shown", {31'b0, inst_valid}, 32'd1);
        tick;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("D_inst_valid_after", {31'b0, inst_valid}, 32'd0);
        chk("D_addr", imem_req_addr, 32'h40);

        // E: misaligned redirect, then reset in the middle of a flush.
        do_reset(2);
        consume = 1'b1;
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        chk("E_redir_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick;
        redirect_valid = 1'b0;
        wait_req("E_wait_req", 10);
        chk("E_addr", imem_req_addr, 32'h100);
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick;
        redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("E_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("E_rst_inst", inst, NOP);
        chk("E_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("E_rst_inst_pc", inst_pc, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("E_restart_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("E_restart_addr", imem_req_addr, 32'h0);

        // F: pc wraps past the top of the address space.
        do_reset(1);
        consume = 1'b1;
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick;
        redirect_valid = 1'b0;
        wait_req("F_wait_top", 10);
        chk("F_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        tick;
        wait_req("F_wait_wrap", 10);
        chk("F_addr_wrap", imem_req_addr, 32'h0);
        repeat (6) tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
